// File: rtl/sequential_unsigned_divider.sv
// sequential_unsigned_divider: restoring shift-subtract divider producing one
// quotient bit per clock. A division takes WIDTH cycles from the accepted start
// edge to done. The timing does not depend on the data, and divide by zero
// takes the same number of cycles.
//
// Optional feature: define DIV_SIGNED_EN to make the operands two's complement.
// Magnitudes go through the unsigned core. The signs are applied when the result
// is registered. The division truncates toward zero.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        request a division (ignored while busy)
//   dividend     numerator, captured on accepted start
//   divisor      denominator, captured on accepted start
//   busy         high while iterating
//   done         result valid, held until next accepted start
//   quotient     registered quotient
//   remainder    registered remainder
//   div_by_zero  captured divisor was zero, valid with done
module sequential_unsigned_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t state, state_nxt;

    // The partial remainder is below 2**(k) after step k, so W-1 bits are
    // enough between steps. The full-width result of the last step goes
    // straight to the output register.
    logic [WIDTH-2:0] rem_r,  rem_nxt;
    logic [WIDTH-1:0] q_r,    q_nxt;
    logic [WIDTH-1:0] dvs_r,  dvs_nxt;
    logic [CNT_W-1:0] cnt_r,  cnt_nxt;
    logic             busy_nxt, done_nxt, dbz_nxt;
    logic [WIDTH-1:0] quo_nxt, rmd_nxt;

    logic             last_c;
    logic [WIDTH-1:0] partial_c;
    logic [WIDTH:0]   diff_c;
    logic             ge_c;
    logic [WIDTH-1:0] rem_step_c;
    logic [WIDTH-1:0] q_step_c;
    logic [WIDTH-1:0] dvd_mag_c, dvs_mag_c;
    logic [WIDTH-1:0] quo_res_c, rem_res_c;

`ifdef DIV_SIGNED_EN
    logic neg_q_r, neg_q_nxt;
    logic neg_r_r, neg_r_nxt;
`endif

    assign last_c = (state == S_RUN) && (cnt_r == CNT_W'(WIDTH - 1));

    // One restoring step. The subtract is one bit wider so the borrow is visible.
    assign partial_c  = {rem_r, q_r[WIDTH-1]};
    assign diff_c     = {1'b0, partial_c} - {1'b0, dvs_r};
    assign ge_c       = ~diff_c[WIDTH];
    assign rem_step_c = ge_c ? diff_c[WIDTH-1:0] : partial_c;
    assign q_step_c   = {q_r[WIDTH-2:0], ge_c};

`ifdef DIV_SIGNED_EN
    // Take the operand magnitudes. The result signs are applied after the last step.
    assign dvd_mag_c = dividend[WIDTH-1] ? -dividend : dividend;
    assign dvs_mag_c = divisor[WIDTH-1]  ? -divisor  : divisor;
    assign quo_res_c = (dvs_r == '0) ? '1 : (neg_q_r ? -q_step_c : q_step_c);
    assign rem_res_c = neg_r_r ? -rem_step_c : rem_step_c;
`else
    assign dvd_mag_c = dividend;
    assign dvs_mag_c = divisor;
    assign quo_res_c = q_step_c;
    assign rem_res_c = rem_step_c;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start)  state_nxt = S_RUN;
            S_RUN:          if (last_c) state_nxt = S_DONE;
            default:                    state_nxt = S_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        rem_nxt  = rem_r;
        q_nxt    = q_r;
        dvs_nxt  = dvs_r;
        cnt_nxt  = cnt_r;
        busy_nxt = busy;
        done_nxt = done;
        quo_nxt  = quotient;
        rmd_nxt  = remainder;
        dbz_nxt  = div_by_zero;
`ifdef DIV_SIGNED_EN
        neg_q_nxt = neg_q_r;
        neg_r_nxt = neg_r_r;
`endif
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    rem_nxt  = '0;
                    q_nxt    = dvd_mag_c;
                    dvs_nxt  = dvs_mag_c;
                    cnt_nxt  = '0;
                    busy_nxt = 1'b1;
                    done_nxt = 1'b0;
                    dbz_nxt  = 1'b0;
`ifdef DIV_SIGNED_EN
                    neg_q_nxt = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    neg_r_nxt = dividend[WIDTH-1];
`endif
                end
            end
            S_RUN: begin
                rem_nxt = rem_step_c[WIDTH-2:0];
                q_nxt   = q_step_c;
                cnt_nxt = cnt_r + CNT_W'(1);
                if (last_c) begin
                    busy_nxt = 1'b0;
                    done_nxt = 1'b1;
                    quo_nxt  = quo_res_c;
                    rmd_nxt  = rem_res_c;
                    dbz_nxt  = (dvs_r == '0);
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r       <= '0;
            q_r         <= '0;
            dvs_r       <= '0;
            cnt_r       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
`endif
        end else begin
            rem_r       <= rem_nxt;
            q_r         <= q_nxt;
            dvs_r       <= dvs_nxt;
            cnt_r       <= cnt_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            quotient    <= quo_nxt;
            remainder   <= rmd_nxt;
            div_by_zero <= dbz_nxt;
`ifdef DIV_SIGNED_EN
            neg_q_r     <= neg_q_nxt;
            neg_r_r     <= neg_r_nxt;
`endif
        end
    end

endmodule

// File: doc/sequential_unsigned_divider.md
Name: sequential_unsigned_divider

Overview:
- Multi-cycle shift-subtract (restoring) divider; the inverse of the team's shift-add sequential multiplier.
- Computes quotient and remainder of dividend / divisor over WIDTH iterations, one quotient bit per clock.
- Sits beside the multiplier in the arithmetic datapath and uses the same start/busy/done-style control.

Parameters:
WIDTH, 8, operand, quotient and remainder width in bits (minimum 2)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a division; sampled only when not busy
dividend  input  WIDTH  numerator, captured on accepted start
divisor  input  WIDTH  denominator, captured on accepted start
busy  output  1  high while iterating
done  output  1  result valid; held until next accepted start
quotient  output  WIDTH  registered quotient
remainder  output  WIDTH  registered remainder
div_by_zero  output  1  captured divisor was zero; valid with done

Behaviour:
- Reset: one clock and one reset. Reset is asynchronous and active-low (rst_n). Asserting rst_n low clears all state immediately:
  - state = IDLE;
  - busy, done, div_by_zero = 0;
  - quotient, remainder = 0;
  - internal remainder register, quotient shift register and iteration counter = 0.
- Reset mid-operation aborts the division; no partial result is exposed.
- States:
  - IDLE: waiting, outputs at reset values.
  - RUN: iterating.
  - DONE: result held.
- Transitions:
  - IDLE or DONE, start=1 at edge T: capture operands, clear the partial remainder, set count=0, go to RUN. From this edge busy=1 and done=0.
  - RUN: each edge performs one step.
    - Step: partial = {rem[WIDTH-2:0], q[WIDTH-1]}; q shifts left.
    - If partial >= divisor: rem = partial - divisor and the new q LSB = 1.
    - Otherwise: rem = partial and the new q LSB = 0.
    - The subtract is WIDTH+1 bits wide to hold the borrow.
  - RUN, after the WIDTH-th step (edge T+WIDTH): register quotient/remainder, go to DONE, busy=0, done=1.
  - DONE: outputs held stable until the next accepted start.
  - start while busy: ignored, and operands are not resampled.
- Latency: done rises WIDTH cycles after the start edge. Throughput is one division per WIDTH+1 cycles when start is pulsed at the earliest opportunity (the cycle done is seen high).
- start asserted in the same cycle done is high is accepted: done falls and busy rises on that edge.
- Divide by zero:
  - No special datapath; the algorithm naturally yields quotient = all ones and remainder = dividend.
  - div_by_zero = 1 is set from the captured divisor and presented with done.
  - Latency is unchanged, so timing is data-independent.
- Dividend < divisor: quotient=0, remainder=dividend.
- Operands are changed on the ports during RUN with no effect.
- Invariant for nonzero divisor: quotient*divisor + remainder == dividend and remainder < divisor.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined: operands are two's complement.
  - On start, magnitudes are captured; the unsigned core runs unchanged.
  - At the DONE transition, quotient is negated if the operand signs differ, and remainder takes the sign of the dividend (truncation toward zero).
  - Most-negative / -1 wraps: quotient = most-negative, remainder = 0.
  - Divide by zero: quotient = all ones, remainder = dividend, div_by_zero = 1.
  - Latency identical.
- Undefined: purely unsigned; no sign logic is synthesised.

Test Plan:
- WIDTH=8, start with 100/7 -> done exactly 8 cycles after the start edge; quotient=14, remainder=2, div_by_zero=0; busy high for those 8 cycles.
- 255/1 then 5/9 back-to-back (start in done cycle) -> 255 r0, then 0 r5; no idle cycle required between them.
- 37/0 -> quotient=0xFF, remainder=37, div_by_zero=1, same 8-cycle latency.
- Start 200/3, pulse rst_n low at cycle 4 -> busy=done=0 immediately, quotient=remainder=0. A new start with 200/3 -> 66 r2.
- Start 90/4, then assert start with 10/10 and change the operand ports mid-RUN -> second start ignored; result 22 r2, with done held until the next start.
- With DIV_SIGNED_EN:
  - -7/2 -> quotient=-3 (0xFD), remainder=-1 (0xFF).
  - -128/-1 -> quotient=0x80, remainder=0.
